pwm_fade_master: RTL
====================

# pwm_fade_master

Wishbone master that sits directly upstream of the 8-channel PWM Wishbone slave and drives its register map autonomously. It optionally writes the per-channel clock-divider shifts once. It then generates a triangle-wave duty level between programmable bounds and writes per-channel thresholds to the slave on every step. The result is hardware breathing/fade of the PWM outputs with no CPU traffic.

## Interface
- NCH, 8, number of PWM channels written per step
- BASE_ADR, 32'hFEED_0000, slave base address; threshold k at BASE_ADR|k, shift k at BASE_ADR|(8+k)
- TIMEOUT, 16, max cycles stb may wait for ack before abort
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous, active-low reset (0 = reset)
- enable_i  in  1  run fade engine
- tick_div_i  in  16  S_WAIT length minus one
- step_i  in  8  level increment per step
- lo_i, hi_i  in  8 each  ramp bounds (inclusive)
- shift_i  in  8  value written to all shift registers during init
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls
- wbm_sel_o  out  4  always 4'b1111
- wbm_adr_o, wbm_dat_o  out  32 each  address / write data
- wbm_ack_i  in  1  slave ack
- busy_o  out  1  high in any state except S_IDLE
- err_o  out  1  sticky timeout flag, cleared only by reset
- level_o  out  8  current ramp value r

## Operation
- States:
  - S_IDLE: bus idle. On enable_i=1: load r=lo_i, dir=up, ch=0. Go to S_INIT if init is pending, else S_WAIT.
  - S_INIT: write shift_i to BASE_ADR|(8+ch) for ch=0..NCH-1. Then set init_done and go to S_WAIT.
  - S_WAIT: counter runs 0..tick_div_i, i.e. tick_div_i+1 cycles. It counts only in this state and clears on exit. At terminal count go to S_STEP.
  - S_STEP: one cycle; update r, set ch=0, go to S_WRITE.
  - S_WRITE: for ch=0..NCH-1, write {24'b0, lvl_ch} to BASE_ADR|ch. Then go to S_WAIT.
- Channel level: lvl_ch = r for even ch, ~r for odd ch (complementary pairs).
- Step arithmetic uses 9-bit intermediates, saturating:
  - Up: r' = min(r+step_i, hi_i); dir flips to down when r' == hi_i.
  - Down: r' = max(r-step_i, lo_i); dir flips to up when r' == lo_i.
- Boundary cases:
  - lo_i >= hi_i: r' = lo_i, dir = up, writes still issued.
  - step_i = 0: r unchanged, writes still issued.
  - r outside [lo_i, hi_i] after a live bound change: clamp on the next step.
- enable_i low in S_WAIT: go to S_IDLE next cycle.
- enable_i low during S_INIT/S_STEP/S_WRITE: finish the current transaction (ack or timeout), then go to S_IDLE. Remaining channels are skipped.
- Timeout: if ack is absent for TIMEOUT cycles with stb high, drop cyc/stb, set err_o, and advance to the next channel as if acked.
- Reset: every register cleared. Outputs: cyc/stb/we = 0, adr = dat = 0, sel = 4'b1111, busy = 0, err = 0, level = 0, init_done = 0.

## Timing
- All outputs are registered.
- cyc, stb and we rise together; adr and dat are valid the same cycle and stable until ack.
- ack sampled high at edge k: cyc/stb/we are low after edge k. The next transaction's stb rises after edge k+1, giving exactly one idle cycle between transactions.
- With an ack one cycle after stb, each write costs 3 cycles.
- Full step period = (tick_div_i+1) + 1 + 3·NCH cycles with an ack-in-one slave. That is 29 cycles for tick_div_i=3, NCH=8.
- ack while stb is low is ignored.
- level_o updates the cycle after S_STEP.

## Configuration
- PWM_FADE_INIT_EN defined: S_INIT runs once after reset, on the first enable. It does not rerun on later re-enables.
- PWM_FADE_INIT_EN undefined: S_INIT and shift_i logic are absent; S_IDLE goes directly to S_WAIT. shift_i stays a port but is unused.

## Structure
- pwm_fade_pkg holds:
  - state enum
  - THRESH_OFS=0, SHIFT_OFS=8
  - default NCH and TIMEOUT
- Sub-module wb_write_master handles single-write Wishbone handshake, idle gap, and timeout. It takes req/adr/dat in and returns done/timeout out.
- The top level holds the FSM, tick counter, and ramp.

## Test plan
- Init with macro defined: enable with shift_i=8'h02 and a slave that acks in one cycle -> 8 writes of 32'h2 to FEED_0008..FEED_000F in order, then the first thresholds. Without the macro: no writes to 0x8–0xF.
- Ramp: lo=8'h10, hi=8'h40, step=8'h10, tick_div=3 -> ch0 values 20,30,40,30,20,10,20 and ch1 values DF,CF,BF,CF,DF,EF,DF. Steps are 29 cycles apart.
- Timeout: slave withholds ack at FEED_0003 -> stb drops after 16 cycles, err_o=1 and stays 1, and the next write goes to FEED_0004.
- Enable drop while the FEED_0002 write is pending -> that transaction completes on ack, no write to FEED_0003, busy_o=0 two cycles later.
- Reset asserted mid-transaction -> cyc/stb=0 and level_o=0 after the next edge. Re-enable restarts from r=lo_i and reruns init if the macro is defined.
- lo_i=hi_i=8'h33 -> every step writes 33 to even channels and CC to odd channels.

Source files
------------

// File: rtl/pwm_fade_pkg.sv
// Shared types, address offsets, defaults and the saturating ramp-step helper
// for the PWM fade master.
package pwm_fade_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT,
        S_STEP,
        S_WRITE
    } state_t;

    typedef struct packed {
        logic [7:0] level;
        logic       up;
    } ramp_t;

    localparam int          THRESH_OFS   = 0;
    localparam int          SHIFT_OFS    = 8;
    localparam int          DEF_NCH      = 8;
    localparam int          DEF_TIMEOUT  = 16;
    localparam logic [31:0] DEF_BASE_ADR = 32'hFEED_0000;

    // One triangle step: saturate at the bound in the travel direction, then
    // clamp into [lo, hi] so a live bound change is absorbed on this step.
    function automatic ramp_t ramp_step(
        input logic [7:0] r,
        input logic       up,
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic [7:0] step
    );
        logic [8:0] sum;
        logic [8:0] dif;
        logic [7:0] cand;
        ramp_t      res;
        sum       = {1'b0, r} + {1'b0, step};
        dif       = {1'b0, r} - {1'b0, step};
        res.level = lo;
        res.up    = 1'b1;
        if (lo < hi) begin
            if (up) begin
                cand = (sum > {1'b0, hi}) ? hi : sum[7:0];
            end else begin
                cand = (dif[8] || (dif[7:0] < lo)) ? lo : dif[7:0];
            end
            if (cand < lo) begin
                res.level = lo;
            end else if (cand > hi) begin
                res.level = hi;
            end else begin
                res.level = cand;
            end
            res.up = up ? (res.level != hi) : (res.level == lo);
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_write_master.sv
// Single-write Wishbone engine: registered cyc/stb/we/adr/dat, one idle cycle
// between writes, and an abort when ack stays away for TIMEOUT cycles.
module wb_write_master
    import pwm_fade_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    input  logic        ack,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_dat,
    output logic        done,
    output logic        timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          to_hit;

    // done is combinational so the caller can advance its channel on the same
    // edge the strobe drops; the next request is then taken one edge later.
    assign to_hit  = stb && !ack && (wait_cnt == TW'(TIMEOUT - 1));
    assign done    = stb && (ack || to_hit);
    assign timeout = to_hit;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cyc      <= 1'b0;
            stb      <= 1'b0;
            we       <= 1'b0;
            bus_adr  <= '0;
            bus_dat  <= '0;
            wait_cnt <= '0;
        end else if (stb) begin
            if (done) begin
                cyc      <= 1'b0;
                stb      <= 1'b0;
                we       <= 1'b0;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TW'(1);
            end
        end else if (req) begin
            cyc     <= 1'b1;
            stb     <= 1'b1;
            we      <= 1'b1;
            bus_adr <= adr;
            bus_dat <= dat;
        end
    end

endmodule

// File: rtl/pwm_fade_master.sv
// Autonomous Wishbone master producing a triangle fade on the PWM slave's
// thresholds. Define PWM_FADE_INIT_EN to write the shift registers once first.
//
// state   | meaning
// S_IDLE  | bus idle, waiting for enable_i
// S_INIT  | writing shift_i to every shift register (PWM_FADE_INIT_EN only)
// S_WAIT  | tick counter runs 0..tick_div_i
// S_STEP  | advance the ramp level one step
// S_WRITE | writing the per-channel thresholds
module pwm_fade_master
    import pwm_fade_pkg::*;
#(
    parameter int          NCH      = DEF_NCH,
    parameter logic [31:0] BASE_ADR = DEF_BASE_ADR,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable_i,
    input  logic [15:0] tick_div_i,
    input  logic [7:0]  step_i,
    input  logic [7:0]  lo_i,
    input  logic [7:0]  hi_i,
    input  logic [7:0]  shift_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [7:0]  level_o
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      tick_cnt;
    logic [7:0]       level;
    logic             up;
    logic [CHW-1:0]   ch;
    logic             last_ch;
    logic [7:0]       lvl_ch;
    logic             busy;
    logic             err;
    logic             init_pending;
    logic             req;
    logic [31:0]      req_adr;
    logic [31:0]      req_dat;
    logic             done;
    logic             timeout;
    ramp_t            ramp_nxt;

`ifdef PWM_FADE_INIT_EN
    logic init_done;
    assign init_pending = !init_done;
`else
    logic unused_shift;
    assign init_pending = 1'b0;
    assign unused_shift = ^shift_i;
`endif

    assign last_ch  = (ch == CHW'(NCH - 1));
    assign lvl_ch   = ch[0] ? ~level : level;
    assign ramp_nxt = ramp_step(level, up, lo_i, hi_i, step_i);

    assign wbm_sel_o = 4'b1111;
    assign busy_o    = busy;
    assign err_o     = err;
    assign level_o   = level;

    // With enable low a write already on the bus still runs to ack/timeout,
    // but no new request is raised, so the remaining channels are skipped.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        req_adr   = BASE_ADR | 32'(THRESH_OFS) | 32'(ch);
        req_dat   = {24'b0, lvl_ch};
        case (state)
            S_IDLE: begin
                if (enable_i) begin
                    state_nxt = init_pending ? S_INIT : S_WAIT;
                end
            end
`ifdef PWM_FADE_INIT_EN
            S_INIT: begin
                req     = enable_i;
                req_adr = BASE_ADR | 32'(SHIFT_OFS) | 32'(ch);
                req_dat = {24'b0, shift_i};
                if (done) begin
                    state_nxt = !enable_i ? S_IDLE : (last_ch ? S_WAIT : S_INIT);
                end else if (!enable_i && !wbm_stb_o) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            S_WAIT: begin
                if (!enable_i) begin
                    state_nxt = S_IDLE;
                end else if (tick_cnt == tick_div_i) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                state_nxt = enable_i ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                req = enable_i;
                if (done) begin
                    state_nxt = !enable_i ? S_IDLE : (last_ch ? S_WAIT : S_WRITE);
                end else if (!enable_i && !wbm_stb_o) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            level     <= '0;
            up        <= 1'b0;
            ch        <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef PWM_FADE_INIT_EN
            init_done <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            tick_cnt <= ((state == S_WAIT) && (state_nxt == S_WAIT)) ? tick_cnt + 16'd1 : '0;
            if (timeout) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (enable_i) begin
                        level <= lo_i;
                        up    <= 1'b1;
                        ch    <= '0;
                    end
                end
                S_STEP: begin
                    level <= ramp_nxt.level;
                    up    <= ramp_nxt.up;
                    ch    <= '0;
                end
                S_INIT, S_WRITE: begin
                    if (done) begin
                        ch <= last_ch ? '0 : ch + CHW'(1);
                    end
                end
                default: ;
            endcase
`ifdef PWM_FADE_INIT_EN
            if ((state == S_INIT) && done && last_ch) begin
                init_done <= 1'b1;
            end
`endif
        end
    end

    wb_write_master #(
        .TIMEOUT(TIMEOUT)
    ) u_wb (
        .clk     (wb_clk_i),
        .rst_b   (wb_rst_i),
        .req     (req),
        .adr     (req_adr),
        .dat     (req_dat),
        .ack     (wbm_ack_i),
        .cyc     (wbm_cyc_o),
        .stb     (wbm_stb_o),
        .we      (wbm_we_o),
        .bus_adr (wbm_adr_o),
        .bus_dat (wbm_dat_o),
        .done    (done),
        .timeout (timeout)
    );

endmodule
